wb_stepgen_multi: RTL and testbench

//  N-channel step/dir pulse generator: successor of the single fixed stepper0 in the newmot top.

---
 rtl/stepgen_pkg.sv | 26 ++
 rtl/stepgen_channel.sv | 184 ++++++++++++++++++
 rtl/wb_stepgen_multi.sv | 93 +++++++++
 tb/tb_wb_stepgen_multi.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepgen_pkg.sv
// stepgen_pkg: shared definitions for the multi-channel step/dir generator.
//   - register offsets within a channel's 16-byte window (word index = adr[3:2])
//   - CTRL register bit positions (write and read views share bit numbers)
//   - per-channel FSM state encoding
package stepgen_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_POS    = 2'd3;

  localparam int CTRL_START  = 0;  // W1: begin a move
  localparam int CTRL_DIR    = 1;  // RW: direction for the next move
  localparam int CTRL_ABORT  = 2;  // W1: stop the running move
  localparam int CTRL_IRQ_EN = 3;  // RW: route done to irq
  localparam int CTRL_BUSY   = 4;  // R : FSM not idle
  localparam int CTRL_DONE   = 5;  // R : move finished / W1C

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

endpackage

// File: rtl/stepgen_channel.sv
// stepgen_channel: one step/dir generator channel with its register bank.
// Optional position counter is compiled in when STEPGEN_POS_EN is defined.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   we              write strobe for this channel (one cycle per bus write)
//   reg_sel         register index (CTRL/PERIOD/COUNT/POS)
//   wdata           write data
//   rdata           combinational read data for reg_sel
//   step, dir       motor outputs
//   irq             done & irq_en
module stepgen_channel
  import stepgen_pkg::*;
#(
  parameter int PERIOD_W  = 24,
  parameter int COUNT_W   = 24,
  parameter int PULSE_W   = 8,
  parameter int DIR_SETUP = 4,
  parameter int POS_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        step,
  output logic        dir,
  output logic        irq
);

  // Timer holds "cycles left minus one" in the current state.
  localparam logic [PERIOD_W-1:0] PER_MIN  = PERIOD_W'(PULSE_W + 1);
  localparam logic [PERIOD_W-1:0] SETUP_LD = PERIOD_W'(DIR_SETUP - 1);
  localparam logic [PERIOD_W-1:0] HIGH_LD  = PERIOD_W'(PULSE_W - 1);

  state_t               state_q, state_d;
  logic [PERIOD_W-1:0]  tmr_q, per_q, per_eff, low_ld;
  logic [COUNT_W-1:0]   rem_q;
  logic                 dir_q, irq_en_q, done_q, abort_q;
  logic                 busy, tmr_zero, rem_zero;
  logic                 wr_ctrl, start_w, abort_w, clr_w, go, zero_start;
  logic                 enter_high, enter_low, finish;
  logic [31:0]          pos_rd;
  logic                 unused_bits;

  assign unused_bits = ^wdata;

  assign busy     = (state_q != ST_IDLE);
  assign tmr_zero = (tmr_q == '0);
  assign rem_zero = (rem_q == '0);

  assign wr_ctrl    = we && (reg_sel == REG_CTRL);
  assign start_w    = wr_ctrl && wdata[CTRL_START];
  assign abort_w    = wr_ctrl && wdata[CTRL_ABORT];
  assign clr_w      = wr_ctrl && wdata[CTRL_DONE];
  assign go         = start_w && !busy && !rem_zero;
  assign zero_start = start_w && !busy && rem_zero;

  // Period shorter than pulse+1 (including 0) is stretched so LOW lasts >= 1 cycle.
  // Sampled at LOW entry, so a PERIOD write mid-move lands on the next LOW.
  assign per_eff = (per_q < PER_MIN) ? PER_MIN : per_q;
  assign low_ld  = per_eff - PER_MIN;

  always_comb begin
    state_d    = state_q;
    enter_high = 1'b0;
    enter_low  = 1'b0;
    finish     = 1'b0;
    case (state_q)
      ST_IDLE:  if (go) state_d = ST_SETUP;
      ST_SETUP: begin
        if (abort_w) begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end else if (tmr_zero) begin
          state_d    = ST_HIGH;
          enter_high = 1'b1;
        end
      end
      ST_HIGH: begin
        // abort during a pulse is deferred to the pulse end: no runt pulses
        if (tmr_zero) begin
          if (abort_q || abort_w) begin
            state_d = ST_IDLE;
            finish  = 1'b1;
          end else begin
            state_d   = ST_LOW;
            enter_low = 1'b1;
          end
        end
      end
      ST_LOW: begin
        if (abort_w) begin
          state_d = ST_IDLE;
          finish  = 1'b1;
        end else if (tmr_zero) begin
          if (!rem_zero) begin
            state_d    = ST_HIGH;
            enter_high = 1'b1;
          end else begin
            state_d = ST_IDLE;
            finish  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q    <= '0;
      per_q    <= '0;
      rem_q    <= '0;
      dir_q    <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      if (go)               tmr_q <= SETUP_LD;
      else if (enter_high)  tmr_q <= HIGH_LD;
      else if (enter_low)   tmr_q <= low_ld;
      else if (!tmr_zero)   tmr_q <= tmr_q - PERIOD_W'(1);

      if (enter_high)
        rem_q <= rem_q - COUNT_W'(1);
      else if (we && (reg_sel == REG_COUNT) && !busy)
        rem_q <= wdata[COUNT_W-1:0];

      if (we && (reg_sel == REG_PERIOD)) per_q <= wdata[PERIOD_W-1:0];
      if (wr_ctrl)                       irq_en_q <= wdata[CTRL_IRQ_EN];
      if (wr_ctrl && !busy)              dir_q <= wdata[CTRL_DIR];

      abort_q <= (state_q == ST_HIGH) && (state_d == ST_HIGH) && (abort_q || abort_w);

      // completion beats a simultaneous W1C
      if (finish || zero_start) done_q <= 1'b1;
      else if (go || clr_w)     done_q <= 1'b0;
    end
  end

`ifdef STEPGEN_POS_EN
  logic [POS_W-1:0] pos_q;

  always_ff @(posedge clk) begin
    if (rst)
      pos_q <= '0;
    else if (enter_high)
      pos_q <= dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
    else if (we && (reg_sel == REG_POS) && !busy)
      pos_q <= wdata[POS_W-1:0];
  end

  assign pos_rd = 32'($signed(pos_q));
`else
  localparam int POS_W_UNUSED = POS_W;
  assign pos_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_DIR]    = dir_q;
        rdata[CTRL_IRQ_EN] = irq_en_q;
        rdata[CTRL_BUSY]   = busy;
        rdata[CTRL_DONE]   = done_q;
      end
      REG_PERIOD: rdata = 32'(per_q);
      REG_COUNT:  rdata = 32'(rem_q);
      default:    rdata = pos_rd;
    endcase
  end

  assign step = (state_q == ST_HIGH);
  assign dir  = dir_q;
  assign irq  = done_q & irq_en_q;

endmodule

// File: rtl/wb_stepgen_multi.sv
// wb_stepgen_multi: N_CH step/dir pulse generators behind a Wishbone slave.
// Address map: adr[6:4] channel, adr[3:2] register; other bits ignored.
// Optional per-channel position counter: define STEPGEN_POS_EN.
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i      bus control
//   wbs_sel_i                 byte select (ignored, full-word access)
//   wbs_adr_i, wbs_dat_i      address, write data
//   wbs_ack_o, wbs_dat_o      one-cycle ack, read data valid with ack
//   step_o, dir_o             per-channel motor outputs
//   irq_o                     registered OR of (done & irq_en)
module wb_stepgen_multi
  import stepgen_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int PERIOD_W  = 24,
  parameter int COUNT_W   = 24,
  parameter int PULSE_W   = 8,
  parameter int DIR_SETUP = 4,
  parameter int POS_W     = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  output logic [N_CH-1:0] step_o,
  output logic [N_CH-1:0] dir_o,
  output logic            irq_o
);

  logic                   req;
  logic [2:0]             ch;
  logic [1:0]             rsel;
  logic [N_CH-1:0]        we_ch, irq_ch;
  logic [N_CH-1:0][31:0]  rd_ch;
  logic [31:0]            rd_mux;
  logic                   unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:7], wbs_adr_i[1:0]};

  // Gating with ~ack forces a low cycle between back-to-back accesses.
  assign req  = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
  assign ch   = wbs_adr_i[6:4];
  assign rsel = wbs_adr_i[3:2];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign we_ch[g] = req && wbs_we_i && (ch == 3'(g));

    stepgen_channel #(
      .PERIOD_W  (PERIOD_W),
      .COUNT_W   (COUNT_W),
      .PULSE_W   (PULSE_W),
      .DIR_SETUP (DIR_SETUP),
      .POS_W     (POS_W)
    ) u_ch (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .we      (we_ch[g]),
      .reg_sel (rsel),
      .wdata   (wbs_dat_i),
      .rdata   (rd_ch[g]),
      .step    (step_o[g]),
      .dir     (dir_o[g]),
      .irq     (irq_ch[g])
    );
  end

  // Channels beyond N_CH read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_CH; i++)
      if (ch == 3'(i)) rd_mux = rd_ch[i];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_o     <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rd_mux : '0;
      irq_o     <= |irq_ch;
    end
  end

endmodule

// File: tb/tb_wb_stepgen_multi.sv
module tb_wb_stepgen_multi;

  localparam int N_CH      = 2;
  localparam int PULSE_W   = 8;
  localparam int DIR_SETUP = 4;
  localparam int R_CTRL = 0, R_PERIOD = 1, R_COUNT = 2, R_POS = 3;

  logic              clk, rst;
  logic              cyc_i, stb_i, we_i;
  logic [3:0]        sel_i;
  logic [31:0]       adr_i, dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [N_CH-1:0]   step_o, dir_o;
  logic              irq_o;

  wb_stepgen_multi #(
    .N_CH(N_CH), .PERIOD_W(24), .COUNT_W(24), .PULSE_W(PULSE_W),
    .DIR_SETUP(DIR_SETUP), .POS_W(32)
  ) dut (
    .wb_clk_i (clk),    .wb_rst_i (rst),
    .wbs_cyc_i(cyc_i),  .wbs_stb_i(stb_i), .wbs_we_i(we_i),
    .wbs_sel_i(sel_i),  .wbs_adr_i(adr_i), .wbs_dat_i(dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .step_o   (step_o), .dir_o    (dir_o), .irq_o    (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycn = 0;
  always @(posedge clk) cycn <= cycn + 1;

  // Edge log: cycle numbers of every step rise/fall per channel.
  int rise_q[N_CH][$];
  int fall_q[N_CH][$];
  logic [N_CH-1:0] step_prev = '0;
  always @(negedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (step_o[c] && !step_prev[c]) rise_q[c].push_back(cycn);
      if (!step_o[c] && step_prev[c]) fall_q[c].push_back(cycn);
    end
    step_prev <= step_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int passed = 0, total = 0;
  int pos_m[N_CH];
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] addr(input int ch, input int rg);
    return (32'(ch) << 4) | (32'(rg) << 2);
  endfunction

  function automatic logic [31:0] ctrl_word(input int st, input int d, input int ab,
                                            input int ie, input int clr);
    return 32'(st | (d << 1) | (ab << 2) | (ie << 3) | (clr << 5));
  endfunction

  task automatic wb_write(input int ch, input int rg, input logic [31:0] d, output int ack_at);
    int lat;
    lat = 99; ack_at = -1;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = addr(ch, rg); dat_i = d;
    for (int i = 1; i <= 8 && ack_at < 0; i++) begin
      @(negedge clk);
      if (wbs_ack_o) begin ack_at = cycn; lat = i; end
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    check($sformatf("wr ack ch%0d r%0d", ch, rg), lat, 1);
  endtask

  task automatic wb_read(input int ch, input int rg, output logic [31:0] d);
    int lat;
    lat = 99; d = '0;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = addr(ch, rg);
    for (int i = 1; i <= 8 && lat == 99; i++) begin
      @(negedge clk);
      if (wbs_ack_o) begin lat = i; d = wbs_dat_o; end
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    check($sformatf("rd ack ch%0d r%0d", ch, rg), lat, 1);
    @(negedge clk);
    check("ack one cycle", 32'(wbs_ack_o), 0);
  endtask

  task automatic clear_q();
    for (int c = 0; c < N_CH; c++) begin
      rise_q[c].delete();
      fall_q[c].delete();
    end
  endtask

  task automatic wait_until(input int t);
    while (cycn < t) @(negedge clk);
  endtask

  // Model: rise k at ack + DIR_SETUP + k*eff, high for PULSE_W cycles.
  task automatic check_train(input string tag, input int c, input int ack_at,
                             input int per, input int cnt);
    int eff;
    eff = (per < PULSE_W + 1) ? PULSE_W + 1 : per;
    check({tag, " nrise"}, rise_q[c].size(), cnt);
    check({tag, " nfall"}, fall_q[c].size(), cnt);
    for (int k = 0; k < cnt; k++) begin
      if (k < rise_q[c].size() && k < fall_q[c].size()) begin
        check($sformatf("%s rise%0d", tag, k), rise_q[c][k] - ack_at, DIR_SETUP + k * eff);
        check($sformatf("%s high%0d", tag, k), fall_q[c][k] - rise_q[c][k], PULSE_W);
      end
    end
  endtask

  task automatic run_train(input string tag, input int ch, input int per,
                           input int cnt, input int d);
    int a, eff;
    eff = (per < PULSE_W + 1) ? PULSE_W + 1 : per;
    wb_write(ch, R_PERIOD, per, a);
    wb_write(ch, R_COUNT, cnt, a);
    clear_q();
    wb_write(ch, R_CTRL, ctrl_word(1, d, 0, 0, 0), a);
    wait_until(a + DIR_SETUP + cnt * eff + 3);
    check_train(tag, ch, a, per, cnt);
    check({tag, " dir"}, 32'(dir_o[ch]), d);
    wb_read(ch, R_CTRL, rd);
    check({tag, " ctrl"}, rd, 32'h20 | 32'(d << 1));
    wb_read(ch, R_COUNT, rd);
    check({tag, " remaining"}, rd, 0);
    pos_m[ch] += d ? cnt : -cnt;
  endtask

  int a0, a1, n, guard;
  int per, cnt, ch, d;

  initial begin
    rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    sel_i = 4'hF; adr_i = '0; dat_i = '0;
    for (int c = 0; c < N_CH; c++) pos_m[c] = 0;
    repeat (3) @(negedge clk);
    check("rst step", 32'(step_o), 0);
    check("rst dir", 32'(dir_o), 0);
    check("rst irq", 32'(irq_o), 0);
    check("rst ack", 32'(wbs_ack_o), 0);
    rst = 1'b0;
    wb_read(0, R_CTRL, rd);   check("rst ctrl", rd, 0);
    wb_read(1, R_PERIOD, rd); check("rst period", rd, 0);

    // Directed trains
    run_train("p20", 0, 20, 3, 1);
    run_train("p5", 0, 5, 2, 0);

    // Randomized trains
    for (int t = 0; t < 4; t++) begin
      ch  = $urandom_range(0, N_CH - 1);
      per = $urandom_range(0, 30);
      cnt = $urandom_range(1, 4);
      d   = $urandom_range(0, 1);
      run_train($sformatf("rnd%0d", t), ch, per, cnt, d);
    end
`ifdef STEPGEN_POS_EN
    for (int c = 0; c < N_CH; c++) begin
      wb_read(c, R_POS, rd);
      check($sformatf("pos model ch%0d", c), rd, 32'(pos_m[c]));
    end
`endif

    // Abort during HIGH; COUNT write while busy is ignored
    wb_write(0, R_PERIOD, 20, a0);
    wb_write(0, R_COUNT, 100, a0);
    clear_q();
    wb_write(0, R_CTRL, ctrl_word(1, 1, 0, 0, 0), a0);
    wb_write(0, R_COUNT, 7, a1);
    n = $urandom_range(1, 3);
    guard = 0;
    while (rise_q[0].size() < n && guard < 200) begin @(negedge clk); guard++; end
    check("abort reach", rise_q[0].size(), n);
    wb_write(0, R_CTRL, ctrl_word(0, 1, 1, 0, 0), a1);
    wait_until(a1 + 40);
    check("abort nrise", rise_q[0].size(), n);
    check("abort nfall", fall_q[0].size(), n);
    if (rise_q[0].size() == n && fall_q[0].size() == n)
      check("abort last high", fall_q[0][n-1] - rise_q[0][n-1], PULSE_W);
    check("abort step", 32'(step_o[0]), 0);
    wb_read(0, R_COUNT, rd); check("abort residual", rd, 100 - n);
    wb_read(0, R_CTRL, rd);  check("abort ctrl", rd, 32'h22);
    pos_m[0] += n;

    // Two channels, independent trains; unmapped channel 5
    wb_write(0, R_PERIOD, 15, a0); wb_write(0, R_COUNT, 3, a0);
    wb_write(1, R_PERIOD, 25, a0); wb_write(1, R_COUNT, 2, a0);
    wb_write(0, R_COUNT, 3, a0);
    clear_q();
    wb_write(0, R_CTRL, ctrl_word(1, 0, 0, 0, 0), a0);
    wb_write(1, R_CTRL, ctrl_word(1, 1, 0, 0, 0), a1);
    wb_read(0, R_CTRL, rd); check("ch0 busy", rd, 32'h10);
    wb_write(5, R_PERIOD, 32'h00FFFF, guard);
    wb_read(5, R_PERIOD, rd); check("ch5 read", rd, 0);
    wait_until(((a0 + 4 + 3 * 15) > (a1 + 4 + 2 * 25) ? (a0 + 4 + 3 * 15) : (a1 + 4 + 2 * 25)) + 3);
    check_train("dual0", 0, a0, 15, 3);
    check_train("dual1", 1, a1, 25, 2);
    check("dual dirs", 32'(dir_o), 2);
    wb_read(0, R_PERIOD, rd); check("ch0 period kept", rd, 15);
    wb_read(1, R_PERIOD, rd); check("ch1 period kept", rd, 25);
    pos_m[0] -= 3; pos_m[1] += 2;

    // COUNT=0 start: immediate done, registered irq, then W1C
    clear_q();
    wb_write(1, R_CTRL, ctrl_word(1, 0, 0, 1, 0), a0);
    check("irq before", 32'(irq_o), 0);
    @(negedge clk);
    check("irq after", 32'(irq_o), 1);
    wb_read(1, R_CTRL, rd); check("zero ctrl", rd, 32'h28);
    check("zero no step", rise_q[1].size(), 0);
    wb_write(1, R_CTRL, ctrl_word(0, 0, 0, 1, 1), a0);
    @(negedge clk); @(negedge clk);
    check("irq cleared", 32'(irq_o), 0);
    wb_read(1, R_CTRL, rd); check("clr ctrl", rd, 32'h08);

`ifdef STEPGEN_POS_EN
    wb_write(0, R_POS, 0, a0);
    pos_m[0] = 0;
    run_train("pos up", 0, 10, 5, 1);
    run_train("pos dn", 0, 10, 2, 0);
    wb_read(0, R_POS, rd); check("pos 3", rd, 3);
    wb_write(0, R_POS, 32'hFFFF_FFFB, a0);
    wb_read(0, R_POS, rd); check("pos neg", rd, 32'hFFFF_FFFB);
`else
    wb_write(0, R_POS, 123, a0);
    wb_read(0, R_POS, rd); check("pos absent", rd, 0);
`endif

    // Reset mid-move
    wb_write(0, R_PERIOD, 20, a0);
    wb_write(0, R_COUNT, 50, a0);
    wb_write(0, R_CTRL, ctrl_word(1, 1, 0, 0, 0), a0);
    guard = 0;
    while (!step_o[0] && guard < 50) begin @(negedge clk); guard++; end
    check("midmove step", 32'(step_o[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst step", 32'(step_o), 0);
    check("midrst dir", 32'(dir_o), 0);
    rst = 1'b0;
    wb_read(0, R_POS, rd);   check("midrst pos", rd, 0);
    wb_read(0, R_COUNT, rd); check("midrst count", rd, 0);
    wb_read(0, R_CTRL, rd);  check("midrst ctrl", rd, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
